// File: rtl/imem_loader_if.sv
// Bundles the two byte/word streams around the instruction-memory loader.
//   rx_data/rx_valid : received byte and its one-cycle strobe (from the UART receiver)
//   we/waddr/wdata   : instruction-RAM write port (byte address, word-aligned)
// master: the loader (consumes bytes, drives RAM writes).
// slave : the environment (UART receiver side plus the RAM).
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output we,
      output waddr,
      output wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  we,
      input  waddr,
      input  wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Parses frames of the form A5, N, N*4 data bytes (little-endian words), XOR checksum,
// writes each assembled word to the instruction RAM at byte address 4*k and keeps the
// core in reset until a full, checksum-verified image has been loaded.
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous, active-high
//   bus         : imem_loader_if.master (byte input stream + RAM write port)
//   cpu_reset_o : core reset, low only after a successful load
//   busy_o      : frame in progress
//   done_o      : last frame loaded correctly (level)
//   error_o     : last frame failed (level)
module imem_loader #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 100_000
) (
   input  logic                clk,
   input  logic                reset,
   imem_loader_if.master       bus,
   output logic                cpu_reset_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o
);

   localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  Header = 8'hA5;

   typedef enum logic [2:0] {
      StIdle, StCount, StData, StCheck, StDone, StError
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        xor_q, xor_d;
   // Only the first three bytes need buffering; the fourth goes straight to wdata.
   logic [23:0]       word_q, word_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              we_q, we_d;
   logic [31:0]       waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              in_frame;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      xor_d       = xor_q;
      word_d      = word_q;
      tmo_d       = '0;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;

      in_frame = (state_q == StCount) || (state_q == StData) || (state_q == StCheck);
      if (in_frame) begin
         tmo_d = bus.rx_valid ? '0 : tmo_q + TmoW'(1);
      end

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (bus.rx_valid && bus.rx_data == Header) begin
               state_d = StCount;
            end
         end
         StCount: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > DEPTH) begin
                  state_d = StError;
               end else begin
                  count_d    = bus.rx_data;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  xor_d      = '0;
                  state_d    = StData;
               end
            end
         end
         StData: begin
            if (bus.rx_valid) begin
               xor_d      = xor_q ^ bus.rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  waddr_d    = {22'd0, word_idx_q, 2'b00};
                  wdata_d    = {bus.rx_data, word_q};
                  word_idx_d = word_idx_q + 8'd1;
                  if (word_idx_q == count_q - 8'd1) begin
                     state_d = StCheck;
                  end
               end else begin
                  word_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
               end
            end
         end
         StCheck: begin
            if (bus.rx_valid) begin
               state_d = (bus.rx_data == xor_q) ? StDone : StError;
            end
         end
         default: state_d = StIdle;
      endcase

      // Inter-byte silence too long: abandon the frame.
      if (in_frame && !bus.rx_valid && tmo_q == TmoW'(TIMEOUT - 1)) begin
         state_d = StError;
      end

      // Status outputs are registered copies of the next-state decode.
      busy_d      = (state_d == StCount) || (state_d == StData) || (state_d == StCheck);
      cpu_reset_d = (state_d != StDone);
      done_d      = (state_d == StDone);
      error_d     = (state_d == StError);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         xor_q       <= '0;
         word_q      <= '0;
         tmo_q       <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         xor_q       <= xor_d;
         word_q      <= word_d;
         tmo_q       <= tmo_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.we      = we_q;
   assign bus.waddr   = waddr_q;
   assign bus.wdata   = wdata_q;
   assign cpu_reset_o = cpu_reset_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;

endmodule
